squeeze_ofm_writer: RTL and testbench
=====================================

Name: squeeze_ofm_writer

Overview:
- Consumer end of the squeeze-layer output interface.
- Captures the DSP_NO-wide parallel ofm vector on each sample pulse from a fire squeeze engine (fire8/fire9).
- Serializes the vector, one channel per cycle, onto a single-port feature-map RAM write port in channel-major layout for the following expand layer.
- Tracks output pixels and signals layer completion and protocol errors.

Parameters:
- WOUT, 8, output feature-map side; WOUT*WOUT pixels per layer.
- DSP_NO, 112, channels per sample (parallel ofm words).
- WIDTH, 16, data word width (signed two's complement).
- AW, $clog2(DSP_NO*WOUT*WOUT), RAM write address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sample_i  in  1  one-cycle pulse; ofm_i valid in the same cycle.
- finish_i  in  1  one-cycle pulse from the engine: layer finished.
- ofm_i  in  WIDTH x [0:DSP_NO-1]  parallel channel outputs.
- wr_en_o  out  1  RAM write strobe.
- wr_addr_o  out  AW  RAM address = ch*WOUT*WOUT + pix.
- wr_data_o  out  WIDTH  RAM write data.
- busy_o  out  1  high while a captured vector is being drained.
- layer_done_o  out  1  one-cycle pulse after the last write of the last pixel.
- overrun_o  out  1  sticky: a sample arrived while busy and could not be accepted.
- count_err_o  out  1  sticky: finish_i arrived with an incomplete pixel count.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; pix=0; ch=0; sticky flags cleared; capture buffer contents are don't-care.
- States:
  - IDLE: sample_i loads ofm_i into the capture buffer, ch=0, next state DRAIN.
  - DRAIN: wr_en_o=1 every cycle; wr_data_o=buf[ch]; wr_addr_o=ch*WOUT*WOUT+pix; ch increments each cycle.
  - DRAIN exit, on the write with ch=DSP_NO-1:
    - pix increments;
    - if pix was WOUT*WOUT-1, pix wraps to 0 and layer_done_o pulses the next cycle;
    - next state IDLE, unless sample_i is high in this cycle, in which case the new vector is captured and DRAIN restarts at ch=0 (gapless).
- Latency: sample at cycle t → first write (ch 0) at t+1 → last write (ch DSP_NO-1) at t+DSP_NO. busy_o=1 over t+1..t+DSP_NO.
- sample_i in DRAIN with ch<DSP_NO-1: sample dropped; overrun_o set; the current drain continues unaffected.
- finish_i:
  - ignored if pix==0 and the state is IDLE or finishing the final pixel (a normal end).
  - otherwise, in IDLE with pix!=0: count_err_o set, pix cleared to 0.
  - otherwise, in DRAIN: the flag is latched and checked when the drain completes.
- finish_i and sample_i in the same IDLE cycle: the sample is accepted and the finish is evaluated after that drain.
- Address arithmetic is unsigned. ch*WOUT*WOUT is computed by an accumulating stride register (adds WOUT*WOUT per channel), not a multiplier.
- Reset mid-drain: the write in flight is abandoned; wr_en_o is 0 the next cycle.

Optional Feature:
- Macro SQUEEZE_WRITER_RELU_EN.
- Defined: wr_data_o = 0 when buf[ch] is negative (MSB=1), else buf[ch]. ReLU is applied at the write port with no added latency.
- Undefined: data is written unmodified.

Decomposition:
- Shared package squeeze_pkg: a typedef for the WIDTH-bit word, the state enum (IDLE, DRAIN), and a localparam function for the address width.
- One natural sub-module, squeeze_fm_addr_gen: holds the ch/pix counters and the stride accumulator, outputs the address plus last_ch and last_pix flags.

Test Plan:
- WOUT=2, DSP_NO=4; one sample with ofm={1,2,3,4} → writes at t+1..t+4 to addr 0,4,8,12 with data 1,2,3,4; busy_o high for exactly 4 cycles.
- 4 samples, each timed on the last write of the previous one → 16 gapless writes; pixel p writes addr ch*4+p; layer_done_o pulses once after addr 15; pix returns to 0.
- Second sample at ch=1 of a drain → overrun_o=1 and stays 1; the first vector is written intact; the second is never written.
- 2 samples then finish_i in IDLE → count_err_o=1; the next sample writes at pix 0 (addr 0).
- With the macro defined, ofm={-5,7,0,-1} → written data {0,7,0,0}; without the macro → {0xFFFB,7,0,0xFFFF}.
- rst asserted at ch=2 → wr_en_o=0 the next cycle; all flags 0; a new sample restarts at addr 0.

Source files
------------

// File: rtl/squeeze_pkg.sv
// Shared types and sizing helpers for the squeeze-layer ofm writer.
package squeeze_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  function automatic int calc_aw(input int dsp_no, input int wout);
    return $clog2(dsp_no * wout * wout);
  endfunction

  // Counter width that stays >= 1 bit for degenerate sizes
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/squeeze_fm_addr_gen.sv
// Channel/pixel counters and channel-major address generation.
// The channel stride (ch*WOUT*WOUT) is accumulated, not multiplied.
module squeeze_fm_addr_gen
  import squeeze_pkg::*;
#(
  parameter int WOUT   = 8,
  parameter int DSP_NO = 112,
  parameter int AW     = calc_aw(DSP_NO, WOUT),
  parameter int CW     = cnt_w(DSP_NO),
  parameter int PW     = cnt_w(WOUT * WOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          clr_pix,
  output logic [CW-1:0] ch,
  output logic [AW-1:0] addr,
  output logic          last_ch,
  output logic          last_pix,
  output logic          pix_zero
);

  localparam int PIX = WOUT * WOUT;
  localparam logic [CW-1:0] CH_LAST  = CW'(DSP_NO - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);

  logic [PW-1:0] pix;
  logic [AW-1:0] stride;

  assign last_ch  = (ch == CH_LAST);
  assign last_pix = (pix == PIX_LAST);
  assign pix_zero = (pix == '0);
  assign addr     = stride + AW'(pix);

  always_ff @(posedge clk) begin
    if (rst) begin
      ch     <= '0;
      stride <= '0;
      pix    <= '0;
    end else begin
      if (step) begin
        if (last_ch) begin
          ch     <= '0;
          stride <= '0;
          pix    <= last_pix ? '0 : pix + 1'b1;
        end else begin
          ch     <= ch + 1'b1;
          stride <= stride + AW'(PIX);
        end
      end
      // An incomplete layer restarts the pixel count, overriding any advance
      if (clr_pix) pix <= '0;
    end
  end

endmodule

// File: rtl/squeeze_ofm_writer.sv
// Captures the parallel squeeze ofm vector and drains it one channel per cycle
// into the feature-map RAM. Optional ReLU at the write port: SQUEEZE_WRITER_RELU_EN.
module squeeze_ofm_writer
  import squeeze_pkg::*;
#(
  parameter int WOUT   = 8,
  parameter int DSP_NO = 112,
  parameter int WIDTH  = 16,
  parameter int AW     = calc_aw(DSP_NO, WOUT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_i,
  input  logic                          finish_i,
  input  logic [DSP_NO-1:0][WIDTH-1:0]  ofm_i,
  output logic                          wr_en_o,
  output logic [AW-1:0]                 wr_addr_o,
  output logic [WIDTH-1:0]              wr_data_o,
  output logic                          busy_o,
  output logic                          layer_done_o,
  output logic                          overrun_o,
  output logic                          count_err_o
);

  localparam int CW = cnt_w(DSP_NO);

  state_t                       state, state_nx;
  logic [DSP_NO-1:0][WIDTH-1:0] cap_q;
  logic                         capture, step;
  logic                         fin_pend, done_q, ovr_q, err_q;
  logic [CW-1:0]                ch;
  logic [AW-1:0]                addr;
  logic                         last_ch, last_pix, pix_zero;
  logic                         drain, exit_w, exit_err, idle_fin;
  logic [WIDTH-1:0]             cur;

  assign drain    = (state == DRAIN);
  assign exit_w   = drain & last_ch;
  // A finish seen during (or at the end of) a drain is only legal on the final pixel
  assign exit_err = exit_w & (fin_pend | finish_i) & ~last_pix;
  assign idle_fin = ~drain & finish_i & ~sample_i & ~pix_zero;

  squeeze_fm_addr_gen #(
    .WOUT(WOUT), .DSP_NO(DSP_NO), .AW(AW), .CW(CW)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .clr_pix  (exit_err | idle_fin),
    .ch       (ch),
    .addr     (addr),
    .last_ch  (last_ch),
    .last_pix (last_pix),
    .pix_zero (pix_zero)
  );

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_i) begin
          capture  = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        step = 1'b1;
        if (last_ch) begin
          capture  = sample_i;
          state_nx = sample_i ? DRAIN : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fin_pend <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= exit_w & last_pix;
      if (drain & sample_i & ~last_ch) ovr_q <= 1'b1;
      if (exit_err | idle_fin)         err_q <= 1'b1;
      if (exit_w)                                fin_pend <= 1'b0;
      else if (finish_i & (drain | sample_i))    fin_pend <= 1'b1;
    end
  end

  // Buffer contents need no reset; they are only read while draining
  always_ff @(posedge clk) begin
    if (capture) cap_q <= ofm_i;
  end

`ifdef SQUEEZE_WRITER_RELU_EN
  assign cur = cap_q[ch][WIDTH-1] ? '0 : cap_q[ch];
`else
  assign cur = cap_q[ch];
`endif

  assign wr_en_o      = drain;
  assign busy_o       = drain;
  assign wr_addr_o    = drain ? addr : '0;
  assign wr_data_o    = drain ? cur : '0;
  assign layer_done_o = done_q;
  assign overrun_o    = ovr_q;
  assign count_err_o  = err_q;

endmodule

// File: tb/tb_squeeze_ofm_writer.sv
// Self-checking bench for squeeze_ofm_writer (WOUT=2, DSP_NO=4): directed
// table/sequences plus randomized traffic against a queue-based write model.
module tb_squeeze_ofm_writer;
  import squeeze_pkg::*;

  localparam int WOUT = 2, DSP_NO = 4, WIDTH = 16, AW = 4, PIX = WOUT * WOUT;

  logic clk = 1'b0, rst = 1'b1, sample_i = 1'b0, finish_i = 1'b0;
  logic [DSP_NO-1:0][WIDTH-1:0] ofm_i = '0;
  logic wr_en_o, busy_o, layer_done_o, overrun_o, count_err_o;
  logic [AW-1:0] wr_addr_o;
  logic [WIDTH-1:0] wr_data_o;

  squeeze_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .finish_i(finish_i), .ofm_i(ofm_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
    .layer_done_o(layer_done_o), .overrun_o(overrun_o), .count_err_o(count_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] w);
`ifdef SQUEEZE_WRITER_RELU_EN
    return w[WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [DSP_NO-1:0][WIDTH-1:0] mk(input int a, input int b, input int c, input int d);
    logic [DSP_NO-1:0][WIDTH-1:0] v;
    v[0] = WIDTH'(a); v[1] = WIDTH'(b); v[2] = WIDTH'(c); v[3] = WIDTH'(d);
    return v;
  endfunction

  // Reference model: a queue of writes still owed to the RAM
  typedef struct { int addr; logic [WIDTH-1:0] data; } wr_t;
  wr_t q[$];
  int  m_pix = 0;
  bit  m_done = 0, m_ovr = 0, m_err = 0, m_fin = 0, model_en = 0;

  logic o_en, o_busy, o_done, o_ovr, o_err;
  logic [AW-1:0] o_addr;
  logic [WIDTH-1:0] o_data;

  task automatic cyc();
    bit idle, last, accept, nd;
    @(negedge clk);
    o_en = wr_en_o; o_busy = busy_o; o_done = layer_done_o;
    o_ovr = overrun_o; o_err = count_err_o; o_addr = wr_addr_o; o_data = wr_data_o;
    if (model_en) begin
      chk("m_wr_en", o_en, q.size() != 0);
      chk("m_busy", o_busy, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_addr", o_addr, q[0].addr);
        chk("m_data", o_data, q[0].data);
      end
      chk("m_done", o_done, m_done);
      chk("m_overrun", o_ovr, m_ovr);
      chk("m_count_err", o_err, m_err);
    end
    if (rst) begin
      q.delete(); m_pix = 0; m_done = 0; m_ovr = 0; m_err = 0; m_fin = 0;
    end else begin
      idle = (q.size() == 0);
      last = (q.size() == 1);
      accept = sample_i && (idle || last);
      nd = 0;
      if (sample_i && !accept) m_ovr = 1;
      if (!idle) void'(q.pop_front());
      if (last) begin
        m_pix++;
        if (m_pix == PIX) begin m_pix = 0; nd = 1; end
        else if (m_fin || finish_i) begin m_err = 1; m_pix = 0; end
        m_fin = 0;
      end else if (!idle && finish_i) m_fin = 1;
      if (idle && finish_i) begin
        if (accept) m_fin = 1;
        else if (m_pix != 0) begin m_err = 1; m_pix = 0; end
      end
      if (accept)
        for (int c = 0; c < DSP_NO; c++) q.push_back('{c * PIX + m_pix, relu(ofm_i[c])});
      m_done = nd;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_i = 1'b0; finish_i = 1'b0;
    cyc(); cyc();
    chk("rst_wr_en", o_en, 0); chk("rst_addr", o_addr, 0); chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0);
    chk("rst_overrun", o_ovr, 0); chk("rst_count_err", o_err, 0);
    rst = 1'b0;
  endtask

  typedef struct { logic [DSP_NO-1:0][WIDTH-1:0] ofm; logic [DSP_NO-1:0][WIDTH-1:0] exp; } vec_t;
  vec_t tbl[3];

  initial begin
    int ndone;
    tbl[0].ofm = mk(1, 2, 3, 4); tbl[0].exp = mk(1, 2, 3, 4);
    tbl[1].ofm = mk(-5, 7, 0, -1);
    tbl[2].ofm = mk('h7FFF, 'h8000, 1, 'h8001);
`ifdef SQUEEZE_WRITER_RELU_EN
    tbl[1].exp = mk(0, 7, 0, 0);
    tbl[2].exp = mk('h7FFF, 0, 1, 0);
`else
    tbl[1].exp = mk('hFFFB, 7, 0, 'hFFFF);
    tbl[2].exp = mk('h7FFF, 'h8000, 1, 'h8001);
`endif

    cyc(); model_en = 1;
    do_reset();

    // Single samples, one pixel each: latency, address layout, data path
    for (int i = 0; i < 3; i++) begin
      sample_i = 1'b1; ofm_i = tbl[i].ofm; cyc(); sample_i = 1'b0; ofm_i = '0;
      for (int c = 0; c < DSP_NO; c++) begin
        cyc();
        chk("t_wr_en", o_en, 1); chk("t_busy", o_busy, 1);
        chk("t_addr", o_addr, c * PIX + i); chk("t_data", o_data, tbl[i].exp[c]);
      end
      cyc(); chk("t_busy_off", o_busy, 0);
    end

    // Gapless full layer
    do_reset();
    sample_i = 1'b1; ofm_i = mk(0, 1, 2, 3); cyc(); sample_i = 1'b0;
    ndone = 0;
    for (int p = 0; p < PIX; p++)
      for (int c = 0; c < DSP_NO; c++) begin
        if (c == DSP_NO - 1 && p < PIX - 1) begin
          sample_i = 1'b1; ofm_i = mk(16*(p+1), 16*(p+1)+1, 16*(p+1)+2, 16*(p+1)+3);
        end
        cyc(); sample_i = 1'b0;
        chk("g_wr_en", o_en, 1); chk("g_addr", o_addr, c * PIX + p);
        chk("g_data", o_data, 16 * p + c);
        ndone += int'(o_done);
      end
    chk("g_no_early_done", ndone, 0);
    cyc(); chk("g_done", o_done, 1); chk("g_idle", o_en, 0);
    cyc(); chk("g_done_pulse", o_done, 0);
    sample_i = 1'b1; ofm_i = mk(9, 9, 9, 9); cyc(); sample_i = 1'b0;
    cyc(); chk("g_wrap_addr", o_addr, 0);
    repeat (4) cyc();

    // Overrun: second sample lands mid-drain
    do_reset();
    sample_i = 1'b1; ofm_i = mk(11, 12, 13, 14); cyc();
    sample_i = 1'b0; cyc();
    sample_i = 1'b1; ofm_i = mk(21, 22, 23, 24); cyc(); sample_i = 1'b0;
    chk("o_ch1_data", o_data, 12);
    cyc(); chk("o_flag", o_ovr, 1); chk("o_ch2_data", o_data, 13);
    cyc(); chk("o_ch3_data", o_data, 14);
    repeat (6) begin cyc(); chk("o_no_write", o_en, 0); end
    chk("o_sticky", o_ovr, 1);

    // Finish with an incomplete pixel count
    do_reset();
    for (int k = 0; k < 2; k++) begin
      sample_i = 1'b1; ofm_i = mk(k, k, k, k); cyc(); sample_i = 1'b0;
      repeat (DSP_NO + 1) cyc();
    end
    finish_i = 1'b1; cyc(); finish_i = 1'b0;
    cyc(); chk("e_flag", o_err, 1);
    sample_i = 1'b1; cyc(); sample_i = 1'b0;
    cyc(); chk("e_restart_addr", o_addr, 0); chk("e_restart_en", o_en, 1);
    repeat (4) cyc();

    // Reset mid-drain
    do_reset();
    sample_i = 1'b1; ofm_i = mk(5, 6, 7, 8); cyc(); sample_i = 1'b0;
    cyc();
    sample_i = 1'b1; cyc(); sample_i = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("r_ch2_inflight", o_data, 7);
    cyc();
    chk("r_wr_en", o_en, 0); chk("r_busy", o_busy, 0);
    chk("r_overrun", o_ovr, 0); chk("r_count_err", o_err, 0); chk("r_done", o_done, 0);
    sample_i = 1'b1; cyc(); sample_i = 1'b0;
    cyc(); chk("r_restart_addr", o_addr, 0); chk("r_restart_data", o_data, 5);
    repeat (4) cyc();

    // Randomized traffic checked against the model every cycle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      sample_i = ($urandom_range(0, 2) == 0);
      finish_i = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < DSP_NO; c++) ofm_i[c] = WIDTH'($urandom);
      cyc();
    end
    sample_i = 1'b0; finish_i = 1'b0; rst = 1'b0;
    repeat (8) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
